// File: rtl/core_fetch_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_fetch_port_pkg
//  Description : Shared micro-architectural types for the core memory ports.
//                Provides the word-address pointer type, the instruction/data
//                word type and the word<->byte address conversion helpers
//                used by both the fetch port and the data port.
//  Revision    : 1.0  initial release
// ============================================================================
package core_fetch_port_pkg;

    localparam int unsigned PTR_W  = 30;
    localparam int unsigned WORD_W = 32;

    // Word-granular address (byte address with the two LSBs dropped).
    typedef logic [PTR_W-1:0]  ptr;
    // One 32-bit bus word.
    typedef logic [WORD_W-1:0] word;

    // Word pointer to byte address: words are 4-byte aligned.
    function automatic logic [31:0] word_to_byte(input ptr p);
        return {p, 2'b00};
    endfunction

    // Byte address to word pointer: the sub-word offset is discarded.
    function automatic ptr byte_to_word(input logic [31:0] b);
        return b[31:2];
    endfunction

endpackage : core_fetch_port_pkg
`default_nettype wire

// File: rtl/core_fetch_hitbuf.sv
`default_nettype none
// ============================================================================
//  Module      : core_fetch_hitbuf
//  Description : One-entry last-fetch buffer. Holds the address, data and
//                valid flag of the most recently filled fetch and reports a
//                hit when a lookup matches.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                lookup_addr       - word address being requested
//                invalidate        - clears the entry (code write)
//                fill_en           - write fill_addr/fill_data into the entry
//                fill_addr         - word address of the fill
//                fill_data         - fetched word of the fill
//                hit               - lookup matches a valid entry
//                buf_data          - stored word (meaningful when hit=1)
//  Revision    : 1.0  initial release
// ============================================================================
module core_fetch_hitbuf
    import core_fetch_port_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  ptr   lookup_addr,
    input  logic invalidate,
    input  logic fill_en,
    input  ptr   fill_addr,
    input  word  fill_data,
    output logic hit,
    output word  buf_data
);

    logic r_buf_valid;
    ptr   r_buf_addr;
    word  r_buf_data;

    // An invalidate arriving together with a lookup must not let a stale
    // entry answer the request, so it masks the hit in the same cycle.
    assign hit      = r_buf_valid && (lookup_addr == r_buf_addr) && !invalidate;
    assign buf_data = r_buf_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else begin
            if (fill_en) begin
                r_buf_addr <= fill_addr;
                r_buf_data <= fill_data;
            end
            // Invalidate takes priority over a coincident fill: the entry
            // may hold code that was just overwritten.
            if (invalidate) begin
                r_buf_valid <= 1'b0;
            end else if (fill_en) begin
                r_buf_valid <= 1'b1;
            end
        end
    end

endmodule : core_fetch_hitbuf
`default_nettype wire

// File: rtl/core_fetch_port.sv
`default_nettype none
// ============================================================================
//  Module      : core_fetch_port
//  Description : Instruction-side responder between the fetch unit and an
//                Avalon-MM style read bus. Single outstanding read; returns
//                each word with a one-cycle fetched pulse. An optional
//                one-word last-fetch buffer answers repeated requests to the
//                same address without a bus cycle.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                fetch, addr         - request valid / word address (IDLE only)
//                invalidate          - clears the last-fetch buffer
//                fetched, fetch_data - registered completion pulse and word
//                bus_read, bus_address, bus_waitrequest,
//                bus_readdata, bus_readdatavalid - memory bus master side
//  Revision    : 1.0  initial release
// ============================================================================
module core_fetch_port
    import core_fetch_port_pkg::*;
#(
    parameter bit HIT_BUFFER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  ptr          addr,
    input  logic        invalidate,
    output logic        fetched,
    output word         fetch_data,
    output logic        bus_read,
    output logic [31:0] bus_address,
    input  logic        bus_waitrequest,
    input  word         bus_readdata,
    input  logic        bus_readdatavalid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    ptr          r_req_addr;
    logic        r_fill_ok;     // 1: the in-flight fill must not be buffered
    logic        r_fetched;
    word         r_fetch_data;
    logic        r_bus_read;
    logic [31:0] r_bus_address;

    logic        w_hit;
    word         w_buf_data;
    logic        w_fill_en;

    // The buffer is written only by a return that no invalidate has touched.
    assign w_fill_en = (r_state == ST_WAIT) && bus_readdatavalid && !r_fill_ok;

    generate
        if (HIT_BUFFER) begin : g_hitbuf
            core_fetch_hitbuf u_hitbuf (
                .clk         (clk),
                .rst         (rst),
                .lookup_addr (addr),
                .invalidate  (invalidate),
                .fill_en     (w_fill_en),
                .fill_addr   (r_req_addr),
                .fill_data   (bus_readdata),
                .hit         (w_hit),
                .buf_data    (w_buf_data)
            );
        end else begin : g_no_hitbuf
            assign w_hit      = 1'b0;
            assign w_buf_data = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req_addr    <= '0;
            r_fill_ok     <= 1'b0;
            r_fetched     <= 1'b0;
            r_fetch_data  <= '0;
            r_bus_read    <= 1'b0;
            r_bus_address <= '0;
        end else begin
            r_fetched <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (fetch) begin
                        if (w_hit) begin
                            r_fetched    <= 1'b1;
                            r_fetch_data <= w_buf_data;
                        end else begin
                            r_req_addr    <= addr;
                            r_fill_ok     <= 1'b0;
                            r_bus_read    <= 1'b1;
                            r_bus_address <= word_to_byte(addr);
                            r_state       <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (invalidate) begin
                        r_fill_ok <= 1'b1;
                    end
                    if (!bus_waitrequest) begin
                        r_bus_read <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (invalidate) begin
                        r_fill_ok <= 1'b1;
                    end
                    if (bus_readdatavalid) begin
                        r_fetch_data <= bus_readdata;
                        r_fetched    <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_bus_read <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign fetched     = r_fetched;
    assign fetch_data  = r_fetch_data;
    assign bus_read    = r_bus_read;
    assign bus_address = r_bus_address;

endmodule : core_fetch_port
`default_nettype wire

// File: tb/tb_core_fetch_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_fetch_port
//  Description : Self-checking bench for core_fetch_port. Directed steps in
//                one initial block; expected fetch words are queued when the
//                return is driven and popped by a monitor on each fetched
//                pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_fetch_port;
    import core_fetch_port_pkg::*;

    logic        clk;
    logic        rst;
    logic        fetch;
    ptr          addr;
    logic        invalidate;
    logic        fetched;
    word         fetch_data;
    logic        bus_read;
    logic [31:0] bus_address;
    logic        bus_waitrequest;
    word         bus_readdata;
    logic        bus_readdatavalid;

    int  checks = 0;
    int  errors = 0;
    word exp_q[$];

    core_fetch_port #(.HIT_BUFFER(1'b1)) dut (
        .clk               (clk),
        .rst               (rst),
        .fetch             (fetch),
        .addr              (addr),
        .invalidate        (invalidate),
        .fetched           (fetched),
        .fetch_data        (fetch_data),
        .bus_read          (bus_read),
        .bus_address       (bus_address),
        .bus_waitrequest   (bus_waitrequest),
        .bus_readdata      (bus_readdata),
        .bus_readdatavalid (bus_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs change and outputs are observed 1 time unit after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every fetched pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (!rst && fetched === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_pulse observed=%h expected=none", fetch_data);
            end
            if (exp_q.size() > 0) begin
                word e;
                e = exp_q.pop_front();
                checks++;
                assert (fetch_data === e) else begin
                    errors++;
                    $error("FAIL fetch_data observed=%h expected=%h", fetch_data, e);
                end
            end
        end
    end

    // Miss from IDLE with `waits` wait states and `delay` extra return cycles.
    task automatic do_miss(input string tag, input ptr a, input word d,
                           input int waits, input int delay);
        fetch = 1'b1;
        addr  = a;
        tick();
        fetch = 1'b0;
        chk({tag, "_bus_read"}, {31'd0, bus_read}, 32'd1);
        chk({tag, "_bus_addr"}, bus_address, {a, 2'b00});
        bus_waitrequest = (waits > 0);
        for (int i = 0; i < waits; i++) begin
            tick();
            if (i == waits - 1) bus_waitrequest = 1'b0;
            chk({tag, "_held_read"}, {31'd0, bus_read}, 32'd1);
            chk({tag, "_held_addr"}, bus_address, {a, 2'b00});
        end
        tick();
        chk({tag, "_read_drop"}, {31'd0, bus_read}, 32'd0);
        for (int i = 0; i < delay; i++) tick();
        bus_readdatavalid = 1'b1;
        bus_readdata      = d;
        exp_q.push_back(d);
        tick();
        bus_readdatavalid = 1'b0;
        bus_readdata      = 32'hDEAD_BEEF;
        chk({tag, "_fetched"}, {31'd0, fetched}, 32'd1);
        tick();
        chk({tag, "_single_pulse"}, {31'd0, fetched}, 32'd0);
    endtask

    initial begin
        rst               = 1'b1;
        fetch             = 1'b0;
        addr              = '0;
        invalidate        = 1'b0;
        bus_waitrequest   = 1'b0;
        bus_readdata      = '0;
        bus_readdatavalid = 1'b0;
        tick();
        tick();
        chk("rst_fetched", {31'd0, fetched}, 32'd0);
        chk("rst_fetch_data", fetch_data, 32'd0);
        chk("rst_bus_read", {31'd0, bus_read}, 32'd0);
        chk("rst_bus_address", bus_address, 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait miss: bus_address 0x400, fetched three cycles after sampling.
        do_miss("miss0", 30'h100, 32'hE3A0_0001, 0, 0);

        // Consecutive hits on the buffered address: no bus traffic.
        exp_q.push_back(32'hE3A0_0001);
        exp_q.push_back(32'hE3A0_0001);
        fetch = 1'b1;
        addr  = 30'h100;
        tick();
        chk("hit1_fetched", {31'd0, fetched}, 32'd1);
        chk("hit1_no_read", {31'd0, bus_read}, 32'd0);
        tick();
        fetch = 1'b0;
        chk("hit2_fetched", {31'd0, fetched}, 32'd1);
        chk("hit2_no_read", {31'd0, bus_read}, 32'd0);
        tick();
        chk("hit_end", {31'd0, fetched}, 32'd0);

        // Three wait states: read held four cycles, fetched at cycle 6.
        do_miss("wait3", 30'h104, 32'h1111_1111, 3, 0);
        // Return delayed two extra cycles.
        do_miss("delay2", 30'h108, 32'h2222_2222, 0, 2);

        // Address change mid-flight, next request sampled in the fetched cycle.
        fetch = 1'b1;
        addr  = 30'h100;
        tick();
        addr = 30'h200;
        chk("chg_addr0", bus_address, 32'h0000_0400);
        tick();
        bus_readdatavalid = 1'b1;
        bus_readdata      = 32'hAAAA_0100;
        exp_q.push_back(32'hAAAA_0100);
        tick();
        bus_readdatavalid = 1'b0;
        chk("chg_fetched", {31'd0, fetched}, 32'd1);
        tick();
        fetch = 1'b0;
        chk("chg_read1", {31'd0, bus_read}, 32'd1);
        chk("chg_addr1", bus_address, 32'h0000_0800);
        chk("chg_no_pulse", {31'd0, fetched}, 32'd0);
        tick();
        bus_readdatavalid = 1'b1;
        bus_readdata      = 32'hBBBB_0200;
        exp_q.push_back(32'hBBBB_0200);
        tick();
        bus_readdatavalid = 1'b0;
        chk("chg_fetched2", {31'd0, fetched}, 32'd1);
        tick();

        // Invalidate during WAIT: data delivered, not buffered.
        fetch = 1'b1;
        addr  = 30'h100;
        tick();
        fetch = 1'b0;
        tick();
        invalidate = 1'b1;
        tick();
        invalidate        = 1'b0;
        bus_readdatavalid = 1'b1;
        bus_readdata      = 32'hCCCC_0001;
        exp_q.push_back(32'hCCCC_0001);
        tick();
        bus_readdatavalid = 1'b0;
        chk("inv_wait_fetched", {31'd0, fetched}, 32'd1);
        tick();
        do_miss("inv_wait_refetch", 30'h100, 32'hCCCC_0002, 0, 0);

        // Invalidate together with a would-be hit: treated as a miss.
        invalidate = 1'b1;
        fetch      = 1'b1;
        addr       = 30'h100;
        tick();
        invalidate = 1'b0;
        fetch      = 1'b0;
        chk("inv_idle_read", {31'd0, bus_read}, 32'd1);
        chk("inv_idle_no_hit", {31'd0, fetched}, 32'd0);
        tick();
        bus_readdatavalid = 1'b1;
        bus_readdata      = 32'hCCCC_0003;
        exp_q.push_back(32'hCCCC_0003);
        tick();
        bus_readdatavalid = 1'b0;
        tick();

        // Invalidate coinciding with the fill cycle: buffer ends invalid.
        fetch = 1'b1;
        addr  = 30'h300;
        tick();
        fetch = 1'b0;
        tick();
        invalidate        = 1'b1;
        bus_readdatavalid = 1'b1;
        bus_readdata      = 32'hDDDD_0300;
        exp_q.push_back(32'hDDDD_0300);
        tick();
        invalidate        = 1'b0;
        bus_readdatavalid = 1'b0;
        chk("inv_fill_fetched", {31'd0, fetched}, 32'd1);
        tick();
        do_miss("inv_fill_refetch", 30'h300, 32'hDDDD_0301, 0, 0);

        // Reset in ISSUE drops the request; a stray return produces no pulse.
        fetch = 1'b1;
        addr  = 30'h3FF;
        tick();
        fetch = 1'b0;
        chk("rstmid_read", {31'd0, bus_read}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_read_off", {31'd0, bus_read}, 32'd0);
        chk("rstmid_no_pulse", {31'd0, fetched}, 32'd0);
        bus_readdatavalid = 1'b1;
        bus_readdata      = 32'h5555_5555;
        tick();
        bus_readdatavalid = 1'b0;
        tick();
        chk("stray_no_pulse", {31'd0, fetched}, 32'd0);
        chk("stray_no_read", {31'd0, bus_read}, 32'd0);

        // Buffer was cleared by reset: 0x300 misses again.
        do_miss("post_rst", 30'h300, 32'h7777_0300, 0, 0);

        tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_core_fetch_port
`default_nettype wire

// File: doc/core_fetch_port.md
# core_fetch_port

Instruction-side responder between the fetch unit and the memory bus. Accepts word-address fetch requests, issues single-outstanding pipelined read transactions (Avalon-MM style) and returns each fetched word with a one-cycle `fetched` pulse. A one-word last-fetch buffer answers repeated requests to the same address without a bus cycle, for example refetches after a flush to the current PC.

## Interface
- `HIT_BUFFER`, default 1: 1 enables the last-fetch buffer; 0 sends every request to the bus.
- `clk` in 1: core clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch` in 1: request valid. Level signal, sampled only in IDLE.
- `addr` in `ptr` (30): word address of the request. Sampled together with `fetch`.
- `invalidate` in 1: one-cycle pulse that clears the last-fetch buffer (used for code writes).
- `fetched` out 1: registered one-cycle pulse. `fetch_data` is valid in that cycle.
- `fetch_data` out `word` (32): registered instruction word. Holds its value between pulses.
- `bus_read` out 1: read request, held until accepted.
- `bus_address` out 32: byte address, `{req_addr, 2'b00}`. Stable while `bus_read`=1.
- `bus_waitrequest` in 1: slave stall. A read is accepted in a cycle with `bus_read`=1 and `bus_waitrequest`=0.
- `bus_readdata` in `word` (32): read return data.
- `bus_readdatavalid` in 1: return strobe. Arrives at least one cycle after acceptance.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE with `fetch`=1 and a buffer hit: the port stays in IDLE. The next cycle shows `fetched`=1 with the buffer data.
  - A buffer hit requires `HIT_BUFFER`=1, `buf_valid`=1 and `addr`==`buf_addr`.
- IDLE with `fetch`=1 and a miss: the port latches `req_addr`=`addr`, clears `fill_ok` and goes to ISSUE.
- ISSUE: `bus_read`=1 at `bus_address`. Leaves for WAIT on the first cycle with `bus_waitrequest`=0.
- WAIT: `bus_read`=0. On `bus_readdatavalid`=1:
  - capture `bus_readdata` into `fetch_data`;
  - pulse `fetched` next cycle;
  - return to IDLE;
  - if `fill_ok`=0, also write the buffer: `buf_addr`=`req_addr`, `buf_data`=`bus_readdata`, `buf_valid`=1.
- Once latched, a request is always completed, even if `addr` changes or `fetch` drops before the return. The fetch unit discards stale returns itself, and the port never aborts a bus transaction.
- The cycle in which `fetched`=1 is an IDLE cycle, so the next request is sampled in that same cycle. The fetch unit presents the advanced address combinationally.
- `bus_readdatavalid` outside WAIT is ignored.
- `invalidate`:
  - clears `buf_valid` in the next cycle;
  - in ISSUE or WAIT, also sets `fill_ok`, so the in-flight fill is delivered but not buffered;
  - when it coincides with the fill cycle, the invalidate wins and the buffer ends up invalid.
- If `invalidate` and a hit lookup happen in the same IDLE cycle, the lookup counts as a miss.

## Timing
- Reset values: state IDLE; `fetched`=0, `fetch_data`=0, `bus_read`=0, `bus_address`=0, `buf_valid`=0, `fill_ok`=0.
- Reset mid-transaction drops the request. The bus shares `rst`, so no stale return follows.
- Hit latency: sample at cycle N, `fetched` at N+1.
- Miss latency: sample at N, `bus_read` from N+1. With zero wait states and return at N+2, `fetched` is at N+3.
- Each wait-state cycle adds one cycle; each cycle of return delay adds one cycle.
- Throughput:
  - misses: at most one per 3 cycles;
  - consecutive hits: one per cycle; `fetched` can stay high on consecutive cycles.
- Exactly one `fetched` pulse per accepted request. No request is accepted outside IDLE.

## Structure
- `ptr` and `word` come from the shared `core/uarch.sv` package.
- The FSM state enum is local to the module.
- The byte/word address conversion helper goes in `core/uarch.sv` for reuse by the data port.
- One sub-module: `core_fetch_hitbuf`, holding the address/data/valid register, compare and invalidate.
  - With `HIT_BUFFER`=0 it is not instantiated and the hit signal is tied to 0.

## Test plan
- Zero-wait miss: `fetch`=1, `addr`=0x100 at cycle 0; slave returns 0xE3A00001 at cycle 2 -> `bus_address`=0x400 at cycle 1, `fetched`=1 with `fetch_data`=0xE3A00001 at cycle 3, single pulse.
- Wait states: `bus_waitrequest`=1 for 3 cycles -> `bus_read` held 4 cycles at a constant address, `fetched` at cycle 6.
- Hit after a flush refetch: fill 0x100, then request 0x100 again -> no `bus_read`, `fetched`=1 one cycle after sampling, same data.
- Address change mid-flight: after issuing 0x100, `addr` switches to 0x200 -> the return for 0x100 is delivered; in the `fetched` cycle 0x200 is sampled and its read is issued at 0x800.
- Invalidate during WAIT for 0x100 -> data delivered; the next request to 0x100 misses and goes to the bus.
- Reset asserted in ISSUE -> next cycle `bus_read`=0 and `fetched`=0; a later `bus_readdatavalid` in IDLE produces no pulse.
